// File: rtl/ball_serve.sv
// Serve controller: parks the ball for a number of frames, then offers random launch parameters.
// Build option BALL_SERVE_AUTOSTART_EN: reset into WAIT and ignore start_i.
`ifndef RND_NUM_W
`define RND_NUM_W 16
`endif

module ball_serve #(
   parameter int RND_W              = `RND_NUM_W,
   parameter int SERVE_DELAY_FRAMES = 60,
   parameter int Y_W                = 10,
   parameter int Y_MIN              = 40,
   parameter int Y_RANGE_LOG2       = 8,
   parameter int SPD_W              = 3,
   parameter int SPD_MIN            = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [RND_W-1:0] rnd_num_i,
   input  logic             frame_tick_i,
   input  logic             start_i,
   input  logic             point_i,
   input  logic             point_side_i,
   output logic             launch_valid_o,
   input  logic             launch_ready_i,
   output logic             dir_x_o,
   output logic             dir_y_o,
   output logic [SPD_W-1:0] speed_y_o,
   output logic [Y_W-1:0]   pos_y_o,
   output logic             serving_o
);

   typedef enum logic [1:0] {IDLE, WAIT, OFFER, PLAY} state_t;

   typedef struct packed {
      logic             dir_x;
      logic             dir_y;
      logic [SPD_W-1:0] speed_y;
      logic [Y_W-1:0]   pos_y;
   } launch_t;

`ifdef BALL_SERVE_AUTOSTART_EN
   localparam state_t RST_STATE = WAIT;
   localparam bit     START_EN  = 1'b0;
`else
   localparam state_t RST_STATE = IDLE;
   localparam bit     START_EN  = 1'b1;
`endif

   localparam logic [7:0] LAST_CNT = 8'(SERVE_DELAY_FRAMES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       hdir_q, hdir_d;
   launch_t    launch_q, launch_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= RST_STATE;
         cnt_q    <= '0;
         hdir_q   <= 1'b0;
         launch_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hdir_q   <= hdir_d;
         launch_q <= launch_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hdir_d   = hdir_q;
      launch_d = launch_q;
      unique case (state_q)
         IDLE: begin
            if (start_i && START_EN) begin
               state_d = WAIT;
               cnt_d   = '0;
               hdir_d  = rnd_num_i[3];
            end
         end
         WAIT: begin
            if (frame_tick_i) begin
               // Last parked frame: freeze this cycle's random word as the serve.
               if (cnt_q == LAST_CNT) begin
                  state_d          = OFFER;
                  launch_d.dir_x   = hdir_q;
                  launch_d.dir_y   = rnd_num_i[0];
                  launch_d.speed_y = SPD_W'(SPD_MIN) + SPD_W'(rnd_num_i[2:1]);
                  launch_d.pos_y   = Y_W'(Y_MIN) + Y_W'(rnd_num_i[RND_W-1 -: Y_RANGE_LOG2]);
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         OFFER: begin
            if (launch_ready_i) state_d = PLAY;
         end
         PLAY: begin
            // Serve goes toward the player who conceded; a same-cycle tick is not counted.
            if (point_i) begin
               state_d = WAIT;
               cnt_d   = '0;
               hdir_d  = ~point_side_i;
            end
         end
         default: state_d = RST_STATE;
      endcase
   end

   assign launch_valid_o = (state_q == OFFER);
   assign serving_o      = (state_q != PLAY);
   assign dir_x_o        = launch_q.dir_x;
   assign dir_y_o        = launch_q.dir_y;
   assign speed_y_o      = launch_q.speed_y;
   assign pos_y_o        = launch_q.pos_y;

   logic unused_ok;
   assign unused_ok = ^{rnd_num_i, start_i};

endmodule

// File: tb/tb_ball_serve.sv
// Bench for ball_serve: vector table, directed corner sequences and random traffic vs a reference model.
module tb_ball_serve;
   localparam int SD = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] rnd = '0;
   logic        tick = 1'b0, start = 1'b0, point = 1'b0, side = 1'b0, ready = 1'b0;
   logic        valid, dx, dy, serving;
   logic [2:0]  sp;
   logic [9:0]  py;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ball_serve #(.SERVE_DELAY_FRAMES(SD)) dut (
      .clk_i(clk), .rst_i(rst), .rnd_num_i(rnd), .frame_tick_i(tick),
      .start_i(start), .point_i(point), .point_side_i(side),
      .launch_valid_o(valid), .launch_ready_i(ready),
      .dir_x_o(dx), .dir_y_o(dy), .speed_y_o(sp), .pos_y_o(py), .serving_o(serving)
   );

   // Reference model: 0 parked before game, 1 counting frames, 2 offering, 3 ball in play.
   int          m_mode = 0;
   int          m_ticks = 0;
   logic        m_hdir = 1'b0, m_dx = 1'b0, m_dy = 1'b0;
   int          m_sp = 0, m_py = 0;

`ifdef BALL_SERVE_AUTOSTART_EN
   localparam int RST_MODE = 1;
`else
   localparam int RST_MODE = 0;
`endif

   function automatic logic [15:0] pack(logic v, logic s, logic x, logic y, int spd, int pos);
      logic [2:0] s3;
      logic [9:0] p10;
      s3  = 3'(spd);
      p10 = 10'(pos);
      return {v, s, x, y, s3, p10};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {valid, serving, dx, dy, sp, py};
   endfunction

   function automatic logic [15:0] model_vec();
      return pack(m_mode == 2, m_mode != 3, m_dx, m_dy, m_sp, m_py);
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h (v,s,dx,dy,sp,py) required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_mode = RST_MODE; m_ticks = 0; m_hdir = 1'b0;
         m_dx = 1'b0; m_dy = 1'b0; m_sp = 0; m_py = 0;
      end else begin
         case (m_mode)
            0: if (start) begin m_mode = 1; m_ticks = 0; m_hdir = rnd[3]; end
            1: if (tick) begin
                  m_ticks++;
                  if (m_ticks == SD) begin
                     m_mode = 2;
                     m_dx = m_hdir;
                     m_dy = rnd[0];
                     m_sp = 1 + int'(rnd[2:1]);
                     m_py = 40 + int'(rnd[15:8]);
                  end
               end
            2: if (ready) m_mode = 3;
            default: if (point) begin m_mode = 1; m_ticks = 0; m_hdir = ~side; end
         endcase
      end
   endtask

   // One clock: model sees the same inputs as the DUT, outputs compared 1 time unit later.
   task automatic step(string name);
      @(posedge clk);
      model_update();
      #1;
      check(name, dut_vec(), model_vec());
      rst = 1'b0; start = 1'b0; point = 1'b0; tick = 1'b0;
   endtask

   typedef struct {
      logic        r, st, pt, sd, tk, rdy;
      logic [15:0] rn;
      logic [15:0] exp;
   } vec_t;

   function automatic vec_t mk(logic r, logic st, logic pt, logic sd, logic tk, logic rdy,
                               logic [15:0] rn, logic [15:0] exp);
      vec_t v;
      v.r = r; v.st = st; v.pt = pt; v.sd = sd; v.tk = tk; v.rdy = rdy; v.rn = rn; v.exp = exp;
      return v;
   endfunction

   initial begin
      vec_t        tbl[$];
      logic [15:0] held;

      step("reset");
      check("reset_vec", dut_vec(), pack(0, 1, 0, 0, 0, 0));

`ifndef BALL_SERVE_AUTOSTART_EN
      //          rst st pt sd tk rdy rnd       expected (v,s,dx,dy,sp,py)
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 16'h0000, pack(0, 1, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'hACE1, pack(0, 1, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0000, pack(0, 1, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0000, pack(0, 1, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'hACE1, pack(1, 1, 0, 1, 1, 212)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, pack(0, 0, 0, 1, 1, 212)));
      tbl.push_back(mk(0, 0, 1, 1, 0, 1, 16'h0000, pack(0, 1, 0, 1, 1, 212)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0000, pack(0, 1, 0, 1, 1, 212)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0000, pack(0, 1, 0, 1, 1, 212)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h1236, pack(1, 1, 0, 0, 4, 58)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, pack(0, 0, 0, 0, 4, 58)));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 16'h0000, pack(0, 1, 0, 0, 4, 58)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0000, pack(0, 1, 0, 0, 4, 58)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0000, pack(0, 1, 0, 0, 4, 58)));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h1236, pack(1, 1, 1, 0, 4, 58)));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFF, pack(0, 0, 1, 0, 4, 58)));
      foreach (tbl[i]) begin
         rst = tbl[i].r; start = tbl[i].st; point = tbl[i].pt; side = tbl[i].sd;
         tick = tbl[i].tk; ready = tbl[i].rdy; rnd = tbl[i].rn;
         step("tbl_model");
         check($sformatf("tbl_row%0d", i), dut_vec(), tbl[i].exp);
      end

      // Stall in OFFER while the random word keeps moving.
      ready = 1'b0; point = 1'b1; side = 1'b1; step("stall_point");
      for (int i = 0; i < SD; i++) begin tick = 1'b1; rnd = 16'($urandom); step("stall_wait"); end
      held = model_vec();
      for (int i = 0; i < 10; i++) begin
         rnd = 16'($urandom); tick = ($urandom_range(1) == 1); step("stall_offer");
         check("stall_hold", dut_vec(), held);
      end
      ready = 1'b1; step("stall_accept");
      check("stall_play", {15'd0, serving}, 16'd0);

      // Tick alongside the point is not counted; stray start/point pulses are ignored.
      point = 1'b1; tick = 1'b1; side = 1'b0; ready = 1'b0; step("pt_tick");
      tick = 1'b1; start = 1'b1; step("wait_t1");
      tick = 1'b1; point = 1'b1; step("wait_t2");
      check("wait_no_valid", {15'd0, valid}, 16'd0);
      tick = 1'b1; step("wait_t3");
      check("third_tick_valid", {15'd0, valid}, 16'd1);
      start = 1'b1; point = 1'b1; step("offer_pulses");
      check("offer_hold_valid", {15'd0, valid}, 16'd1);
      ready = 1'b1; step("accept2");

      // Reset in WAIT after two ticks, then a full delay is needed again.
      point = 1'b1; step("rst_wait_pt");
      tick = 1'b1; step("rst_wait_t1");
      tick = 1'b1; step("rst_wait_t2");
      rst = 1'b1; step("rst_in_wait");
      check("rst_wait_vec", dut_vec(), pack(0, 1, 0, 0, 0, 0));
      tick = 1'b1; step("idle_tick");
      start = 1'b1; rnd = 16'h0008; step("restart");
      tick = 1'b1; step("restart_t1");
      tick = 1'b1; step("restart_t2");
      check("restart_no_valid", {15'd0, valid}, 16'd0);
      tick = 1'b1; rnd = 16'h0000; ready = 1'b0; step("restart_t3");
      check("restart_dirx", {14'd0, valid, dx}, 16'd3);
      rst = 1'b1; step("rst_in_offer");
      check("rst_offer_vec", dut_vec(), pack(0, 1, 0, 0, 0, 0));
`else
      ready = 1'b0;
      for (int i = 0; i < SD - 1; i++) begin tick = 1'b1; start = 1'b1; step("auto_tick"); end
      check("auto_no_valid", {15'd0, valid}, 16'd0);
      tick = 1'b1; rnd = 16'h0008; step("auto_last");
      check("auto_valid_left", {14'd0, valid, dx}, 16'd2);
      rst = 1'b1; step("auto_rst");
`endif

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(199) == 0);
         start = ($urandom_range(7) == 0);
         point = ($urandom_range(5) == 0);
         side  = 1'($urandom_range(1));
         tick  = ($urandom_range(2) == 0);
         ready = ($urandom_range(3) != 0);
         rnd   = 16'($urandom);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
